min_search_stream: RTL and testbench

Streaming, parametrised argmin engine for the associative memory. It computes the minimum Hamming distance and its class index over a programmable number of classes, fed as `NumLanes` distances per beat under a valid/ready handshake. Each beat is reduced by a registered binary compare tree and folded into a running best. The block also reports whether the winning distance meets a programmable threshold. It sits between the distance-computation array and the result CSRs/stream.

---
 rtl/min_search_stream_if.sv | 35 +++
 rtl/min_search_stream.sv | 165 ++++++++++++++++
 tb/tb_min_search_stream.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/min_search_stream_if.sv
// Purpose: handshake/bus bundle for the streaming argmin engine.
//   slave  : seen by min_search_stream (control + beat stream in, result out)
//   master : seen by the producer/consumer driving the engine
// Signals: start_i, num_classes_i, threshold_i, dist_i, dist_valid_i,
//          dist_ready_o, busy_o, result_valid_o, result_ready_i,
//          min_value_o, min_index_o, hit_o
interface min_search_stream_if #(
  parameter int unsigned DistWidth  = 16,
  parameter int unsigned NumLanes   = 8,
  parameter int unsigned MaxClasses = 1024,
  parameter int unsigned IdxWidth   = $clog2(MaxClasses)
);
  logic                          start_i;
  logic [IdxWidth:0]             num_classes_i;
  logic [DistWidth-1:0]          threshold_i;
  logic [NumLanes*DistWidth-1:0] dist_i;
  logic                          dist_valid_i;
  logic                          dist_ready_o;
  logic                          busy_o;
  logic                          result_valid_o;
  logic                          result_ready_i;
  logic [DistWidth-1:0]          min_value_o;
  logic [IdxWidth-1:0]           min_index_o;
  logic                          hit_o;

  modport slave (
    input  start_i, num_classes_i, threshold_i, dist_i, dist_valid_i, result_ready_i,
    output dist_ready_o, busy_o, result_valid_o, min_value_o, min_index_o, hit_o
  );

  modport master (
    output start_i, num_classes_i, threshold_i, dist_i, dist_valid_i, result_ready_i,
    input  dist_ready_o, busy_o, result_valid_o, min_value_o, min_index_o, hit_o
  );
endinterface

// File: rtl/min_search_stream.sv
// Purpose: streaming argmin over N classes delivered NumLanes distances per beat.
//   Each accepted beat is reduced by a compare tree into a stage register and
//   then folded into a running best; reports min value, its class index and
//   whether it meets the threshold latched at start.
// Ports: clk_i, rst_ni (async active-low), bus (min_search_stream_if.slave)
module min_search_stream #(
  parameter int unsigned DistWidth  = 16,
  parameter int unsigned NumLanes   = 8,
  parameter int unsigned MaxClasses = 1024,
  parameter int unsigned IdxWidth   = $clog2(MaxClasses)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  min_search_stream_if.slave   bus
);
  localparam int unsigned LaneBits = $clog2(NumLanes);
  localparam int unsigned CntWidth = IdxWidth + 1;
  localparam int unsigned NodeCnt  = 2 * NumLanes - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e               r_state;
  logic [CntWidth-1:0]  r_n;
  logic [CntWidth-1:0]  r_last;
  logic [CntWidth-1:0]  r_beat;
  logic [DistWidth-1:0] r_thr;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_rvalid;
  logic                 r_stg_vld;
  logic [DistWidth-1:0] r_stg_val;
  logic [IdxWidth-1:0]  r_stg_idx;
  logic                 r_seen;
  logic [DistWidth-1:0] r_best;
  logic [IdxWidth-1:0]  r_best_idx;
  logic                 r_hit;

  logic                 w_acc;
  logic [CntWidth-1:0]  w_base;
  logic                 w_take;
  logic [DistWidth-1:0] w_new_best;

  // Heap-ordered compare tree: node i has children 2i+1 / 2i+2, leaves hold lanes in order
  logic [DistWidth-1:0] w_nval [NodeCnt];
  logic [LaneBits-1:0]  w_nidx [NodeCnt];
  logic                 w_nvld [NodeCnt];

  assign w_acc  = r_ready & bus.dist_valid_i;
  assign w_base = CntWidth'(r_beat << LaneBits);

  // Beat reduction; lanes past N are masked, left (lower lane) wins ties
  always_comb begin
    for (int i = 0; i < int'(NodeCnt); i++) begin
      w_nval[i] = '1;
      w_nidx[i] = '0;
      w_nvld[i] = 1'b0;
    end
    for (int j = 0; j < int'(NumLanes); j++) begin
      w_nval[int'(NumLanes) - 1 + j] = bus.dist_i[j*DistWidth +: DistWidth];
      w_nidx[int'(NumLanes) - 1 + j] = LaneBits'(j);
      w_nvld[int'(NumLanes) - 1 + j] = (CntWidth'(w_base + CntWidth'(j)) < r_n);
    end
    for (int i = int'(NumLanes) - 2; i >= 0; i--) begin
      if (w_nvld[2*i+1] && (!w_nvld[2*i+2] || (w_nval[2*i+1] <= w_nval[2*i+2]))) begin
        w_nval[i] = w_nval[2*i+1];
        w_nidx[i] = w_nidx[2*i+1];
        w_nvld[i] = 1'b1;
      end else begin
        w_nval[i] = w_nval[2*i+2];
        w_nidx[i] = w_nidx[2*i+2];
        w_nvld[i] = w_nvld[2*i+2];
      end
    end
  end

  // Strict less-than keeps the earlier (lower) index on cross-beat ties
  assign w_take     = r_stg_vld & (~r_seen | (r_stg_val < r_best));
  assign w_new_best = w_take ? r_stg_val : r_best;

  // Control FSM, stage register and running-best fold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_n        <= '0;
      r_last     <= '0;
      r_beat     <= '0;
      r_thr      <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_rvalid   <= 1'b0;
      r_stg_vld  <= 1'b0;
      r_stg_val  <= '1;
      r_stg_idx  <= '0;
      r_seen     <= 1'b0;
      r_best     <= '1;
      r_best_idx <= '0;
      r_hit      <= 1'b0;
    end else begin
      if (r_stg_vld) begin
        r_seen <= 1'b1;
        r_hit  <= (w_new_best <= r_thr);
        if (w_take) begin
          r_best     <= r_stg_val;
          r_best_idx <= r_stg_idx;
        end
      end

      r_stg_vld <= w_acc & w_nvld[0];
      if (w_acc) begin
        r_stg_val <= w_nval[0];
        r_stg_idx <= IdxWidth'(w_base + CntWidth'(w_nidx[0]));
        r_beat    <= r_beat + CntWidth'(1);
      end

      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_n        <= bus.num_classes_i;
            r_thr      <= bus.threshold_i;
            // Index of the final beat: ceil(N/NumLanes)-1
            r_last     <= CntWidth'((bus.num_classes_i - CntWidth'(1)) >> LaneBits);
            r_beat     <= '0;
            r_best     <= '1;
            r_best_idx <= '0;
            r_seen     <= 1'b0;
            r_hit      <= 1'b0;
            r_busy     <= 1'b1;
            if (bus.num_classes_i != '0) begin
              r_state <= RUN;
              r_ready <= 1'b1;
            end else begin
              r_state  <= DONE;
              r_rvalid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_acc && (r_beat == r_last)) begin
            r_state <= DRAIN;
            r_ready <= 1'b0;
          end
        end
        DRAIN: begin
          r_state  <= DONE;
          r_rvalid <= 1'b1;
        end
        DONE: begin
          if (bus.result_ready_i) begin
            r_state  <= IDLE;
            r_rvalid <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dist_ready_o   = r_ready;
  assign bus.busy_o         = r_busy;
  assign bus.result_valid_o = r_rvalid;
  assign bus.min_value_o    = r_best;
  assign bus.min_index_o    = r_best_idx;
  assign bus.hit_o          = r_hit;
endmodule

// File: tb/tb_min_search_stream.sv
// Purpose: directed self-checking bench for min_search_stream.
module tb_min_search_stream;
  localparam int unsigned DW = 16;
  localparam int unsigned NL = 8;
  localparam int unsigned MC = 1024;
  localparam int unsigned IW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  min_search_stream_if #(.DistWidth(DW), .NumLanes(NL), .MaxClasses(MC), .IdxWidth(IW)) bus ();

  min_search_stream #(.DistWidth(DW), .NumLanes(NL), .MaxClasses(MC), .IdxWidth(IW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [DW-1:0] cls [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int i = 0; i < 64; i++) cls[i] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_search(input int n, input logic [DW-1:0] thr);
    bus.num_classes_i = (IW+1)'(n);
    bus.threshold_i   = thr;
    bus.start_i       = 1'b1;
    tick();
    bus.start_i       = 1'b0;
  endtask

  task automatic send_beats(input int nb, input bit gaps, input bit no_stall);
    for (int k = 0; k < nb; k++) begin
      int w;
      if (gaps) begin
        bus.dist_valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      for (int j = 0; j < int'(NL); j++) bus.dist_i[j*DW +: DW] = cls[k*int'(NL) + j];
      bus.dist_valid_i = 1'b1;
      @(negedge clk);
      w = 0;
      while (!bus.dist_ready_o && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("dist_ready", 32'(bus.dist_ready_o), 32'd1);
      if (no_stall) check("ready_no_stall", 32'(w), 32'd0);
      tick();
      bus.dist_valid_i = 1'b0;
    end
  endtask

  // Called right after the last-beat handshake edge
  task automatic expect_result(input logic [DW-1:0] val, input int idx, input bit hit);
    @(negedge clk);
    check("rvalid_in_drain", 32'(bus.result_valid_o), 32'd0);
    check("ready_in_drain", 32'(bus.dist_ready_o), 32'd0);
    @(negedge clk);
    check("rvalid_latency", 32'(bus.result_valid_o), 32'd1);
    check("busy_done", 32'(bus.busy_o), 32'd1);
    check("min_value", 32'(bus.min_value_o), 32'(val));
    check("min_index", 32'(bus.min_index_o), 32'(idx));
    check("hit", 32'(bus.hit_o), 32'(hit));
  endtask

  task automatic finish_result();
    bus.result_ready_i = 1'b1;
    tick();
    bus.result_ready_i = 1'b0;
    @(negedge clk);
    check("busy_after_ack", 32'(bus.busy_o), 32'd0);
    check("rvalid_after_ack", 32'(bus.result_valid_o), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(bus.dist_ready_o), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    check({tag, "_rvalid"}, 32'(bus.result_valid_o), 32'd0);
    check({tag, "_value"}, 32'(bus.min_value_o), 32'hFFFF);
    check({tag, "_index"}, 32'(bus.min_index_o), 32'd0);
    check({tag, "_hit"}, 32'(bus.hit_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start_i        = 1'b0;
    bus.num_classes_i  = '0;
    bus.threshold_i    = '0;
    bus.dist_i         = '0;
    bus.dist_valid_i   = 1'b0;
    bus.result_ready_i = 1'b0;

    // Reset state
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // Single minimum, back-to-back beats
    fill(16'd500);
    cls[19] = 16'd3;
    start_search(32, 16'd0);
    send_beats(4, 1'b0, 1'b1);
    expect_result(16'd3, 19, 1'b0);
    finish_result();

    // Cross-beat tie keeps the lower index; threshold equal to min hits
    fill(16'd200);
    cls[5] = 16'd7;
    cls[21] = 16'd7;
    start_search(32, 16'd7);
    send_beats(4, 1'b0, 1'b0);
    expect_result(16'd7, 5, 1'b1);
    finish_result();

    // Same-beat tie keeps the lower lane
    fill(16'd200);
    cls[2] = 16'd7;
    cls[3] = 16'd7;
    start_search(32, 16'd0);
    send_beats(4, 1'b0, 1'b0);
    expect_result(16'd7, 2, 1'b0);
    finish_result();

    // Partial final beat: lanes past N carry zeros but must not win
    fill(16'd50);
    cls[12] = 16'd9;
    cls[13] = 16'd0;
    cls[14] = 16'd0;
    cls[15] = 16'd0;
    start_search(13, 16'd100);
    send_beats(2, 1'b0, 1'b0);
    expect_result(16'd9, 12, 1'b1);
    finish_result();

    // Valid gaps, result backpressure with start_i ignored
    fill(16'd1000);
    cls[30] = 16'd1;
    cls[31] = 16'd2;
    start_search(32, 16'd0);
    send_beats(4, 1'b1, 1'b0);
    expect_result(16'd1, 30, 1'b0);
    bus.start_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_rvalid", 32'(bus.result_valid_o), 32'd1);
      check("hold_value", 32'(bus.min_value_o), 32'd1);
      check("hold_index", 32'(bus.min_index_o), 32'd30);
    end
    // start_i stays high across the accepting edge and must not restart
    bus.result_ready_i = 1'b1;
    tick();
    bus.result_ready_i = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy_o), 32'd0);
    check("idle_rvalid", 32'(bus.result_valid_o), 32'd0);
    @(negedge clk);
    check("idle_stays", 32'(bus.busy_o), 32'd0);

    // Threshold just missed
    fill(16'd20);
    cls[4] = 16'd11;
    start_search(8, 16'd10);
    send_beats(1, 1'b0, 1'b0);
    expect_result(16'd11, 4, 1'b0);
    finish_result();

    // Threshold exactly met
    cls[4] = 16'd10;
    start_search(8, 16'd10);
    send_beats(1, 1'b0, 1'b0);
    expect_result(16'd10, 4, 1'b1);
    finish_result();

    // N = 0 completes immediately with the empty result
    start_search(0, 16'hFFFF);
    @(negedge clk);
    check("n0_rvalid", 32'(bus.result_valid_o), 32'd1);
    check("n0_ready", 32'(bus.dist_ready_o), 32'd0);
    check("n0_value", 32'(bus.min_value_o), 32'hFFFF);
    check("n0_index", 32'(bus.min_index_o), 32'd0);
    check("n0_hit", 32'(bus.hit_o), 32'd0);
    finish_result();

    // Async reset after two of four beats
    fill(16'd100);
    cls[3] = 16'd5;
    start_search(32, 16'd100);
    send_beats(2, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_reset_value", 32'(bus.min_value_o), 32'd5);
    check("pre_reset_busy", 32'(bus.busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fresh search after reset
    fill(16'd60);
    cls[6] = 16'd4;
    start_search(8, 16'd4);
    send_beats(1, 1'b0, 1'b1);
    expect_result(16'd4, 6, 1'b1);
    finish_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
